cb_cfg_loader: RTL

CB_CFG_LOADER -- requirements
Module: cb_cfg_loader

---
 rtl/cb_cfg_pkg.sv | 22 ++
 rtl/cb_cfg_deser.sv | 28 ++
 rtl/cb_cfg_loader.sv | 116 +++++++++++
 3 files changed

// File: rtl/cb_cfg_pkg.sv
// Shared constants and state type for the connection-block serial config loader.
// Optional trailing parity bit is enabled by defining CB_CFG_PARITY_EN.
package cb_cfg_pkg;

  localparam logic [7:0] CB_SYNC = 8'hA5;
  localparam int ADDR_W   = 4;
  localparam int SEL_W    = 10;
  localparam int SYNC_LEN = 8;
  localparam int ADDR_LEN = ADDR_W;
  localparam int DATA_LEN = SEL_W + 1;
`ifdef CB_CFG_PARITY_EN
  localparam int PAR_LEN  = 1;
`else
  localparam int PAR_LEN  = 0;
`endif
  // Bits that follow the sync pattern; these are the bits the deserialiser collects.
  localparam int FRAME_LEN = ADDR_LEN + DATA_LEN + PAR_LEN;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {HUNT, ADDR, DATA, PAR} state_t;

endpackage

// File: rtl/cb_cfg_deser.sv
// Counted serial-to-parallel shifter; shifts MSB-first on en, holds otherwise.
// clr empties the register and the count in the same cycle and overrides en.
module cb_cfg_deser
  import cb_cfg_pkg::*;
#(
  parameter int W  = 15,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          din,
  output logic [W-1:0]  shreg,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (en) begin
      shreg <= {shreg[W-2:0], din};
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cb_cfg_loader.sv
// Serial loader for NUM_CB connection-block sel/q registers: sync A5, addr, sel, q.
// Defining CB_CFG_PARITY_EN appends a required even-parity bit to every frame.
module cb_cfg_loader
  import cb_cfg_pkg::*;
#(
  parameter int NUM_CB = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_din,
  input  logic                    cfg_valid,
  input  logic                    cfg_abort,
  output logic [NUM_CB*SEL_W-1:0] sel_flat,
  output logic [NUM_CB-1:0]       q_flat,
  output logic                    busy,
  output logic                    cfg_done,
  output logic                    cfg_err
);

  state_t                 state;
  logic [SYNC_LEN-1:0]    window;
  logic [SYNC_LEN-1:0]    window_nxt;
  logic [FRAME_LEN-2:0]   shreg;
  logic [CNT_W-1:0]       cnt;
  logic [FRAME_LEN-1:0]   word;
  logic [ADDR_W-1:0]      addr;
  logic [SEL_W-1:0]       sel;
  logic                   q;
  logic                   accept;
  logic                   last;
  logic                   bad_frame;

  assign accept     = cfg_valid && !cfg_abort;
  assign last       = accept && (state != HUNT) && (cnt == CNT_W'(FRAME_LEN - 1));
  assign window_nxt = {window[SYNC_LEN-2:0], cfg_din};
  assign busy       = (state != HUNT);

  // The final bit is still on cfg_din at commit time, so splice it onto the register.
  assign word = {shreg, cfg_din};
  assign addr = word[FRAME_LEN-1 -: ADDR_W];
  assign sel  = word[FRAME_LEN-1-ADDR_W -: SEL_W];
  assign q    = word[PAR_LEN];

`ifdef CB_CFG_PARITY_EN
  assign bad_frame = (int'(addr) >= NUM_CB) || (^word);
`else
  assign bad_frame = (int'(addr) >= NUM_CB);
`endif

  cb_cfg_deser #(
    .W  (FRAME_LEN - 1),
    .CW (CNT_W)
  ) u_deser (
    .clk   (clk),
    .rst   (rst),
    .clr   (cfg_abort || (state == HUNT) || last),
    .en    (accept && (state != HUNT)),
    .din   (cfg_din),
    .shreg (shreg),
    .cnt   (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      window   <= '0;
      sel_flat <= '0;
      q_flat   <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      if (cfg_abort) begin
        state  <= HUNT;
        window <= '0;
      end else if (cfg_valid) begin
        case (state)
          HUNT: begin
            if (window_nxt == CB_SYNC) begin
              state  <= ADDR;
              window <= '0;
            end else begin
              window <= window_nxt;
            end
          end
          ADDR: if (cnt == CNT_W'(ADDR_LEN - 1)) state <= DATA;
          DATA: begin
            if (cnt == CNT_W'(ADDR_LEN + DATA_LEN - 1)) begin
`ifdef CB_CFG_PARITY_EN
              state <= PAR;
`else
              state <= HUNT;
`endif
            end
          end
          default: state <= HUNT;
        endcase
      end
      if (last) begin
        if (bad_frame) begin
          cfg_err <= 1'b1;
        end else begin
          cfg_done <= 1'b1;
          for (int k = 0; k < NUM_CB; k++) begin
            if (int'(addr) == k) begin
              sel_flat[k*SEL_W +: SEL_W] <= sel;
              q_flat[k]                  <= q;
            end
          end
        end
      end
    end
  end

endmodule
